// File: rtl/pe_pkg.sv
// Shared types and default sizing for the PE row feeder slice.
package pe_pkg;

    localparam int PE_DATA_WIDTH = 16;
    localparam int PE_MAX_S      = 8;
    localparam int PE_MAX_W      = 256;

    typedef logic [PE_DATA_WIDTH-1:0] data_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_F,
        FILL,
        COMPUTE,
        SHIFT
    } feeder_state_t;

endpackage

// File: rtl/pe_window_buf.sv
// Sliding ifmap window: indexed parallel load during fill, shift-in at the
// last live slot (last_idx) so shorter filters never touch the unused tail.
module pe_window_buf
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH = PE_DATA_WIDTH,
    parameter int MAX_S      = PE_MAX_S,
    parameter int S_W        = $clog2(MAX_S + 1),
    parameter int IDX_W      = (MAX_S > 1) ? $clog2(MAX_S) : 1
) (
    input  logic                  clk,
    input  logic                  load_en,
    input  logic [IDX_W-1:0]      load_idx,
    input  logic                  shift_en,
    input  logic [S_W-1:0]        last_idx,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] win [MAX_S];

    for (genvar i = 0; i < MAX_S; i++) begin : g_slot
        if (i < MAX_S - 1) begin : g_mid
            always_ff @(posedge clk) begin
                if (load_en && load_idx == IDX_W'(i)) begin
                    win[i] <= din;
                end else if (shift_en) begin
                    if (last_idx == S_W'(i)) begin
                        win[i] <= din;
                    end else if (S_W'(i) < last_idx) begin
                        win[i] <= win[i+1];
                    end
                end
            end
        end else begin : g_top
            always_ff @(posedge clk) begin
                if (load_en && load_idx == IDX_W'(i)) begin
                    win[i] <= din;
                end else if (shift_en && last_idx == S_W'(i)) begin
                    win[i] <= din;
                end
            end
        end
    end

    assign rd_data = win[rd_idx];

endmodule

// File: rtl/pe_row_feeder.sv
// Row-convolution operand sequencer: loads S filter taps, buffers an S-wide
// ifmap window and streams one (ifmap, filter) pair per cycle to the PE.
module pe_row_feeder
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH = PE_DATA_WIDTH,
    parameter int MAX_S      = PE_MAX_S,
    parameter int MAX_W      = PE_MAX_W,
    parameter int S_W        = $clog2(MAX_S + 1),
    parameter int W_W        = $clog2(MAX_W + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [S_W-1:0]        cfg_s,
    input  logic [W_W-1:0]        cfg_w,
    input  logic [DATA_WIDTH-1:0] fltr_data,
    input  logic                  fltr_valid,
    output logic                  fltr_ready,
    input  logic [DATA_WIDTH-1:0] ifmap_data,
    input  logic                  ifmap_valid,
    output logic                  ifmap_ready,
    output logic [DATA_WIDTH-1:0] pe_ifmap,
    output logic [DATA_WIDTH-1:0] pe_fltr,
    output logic                  pe_mult_seln,
    output logic                  pe_acc_seln,
    output logic                  pe_tap_valid,
    output logic                  pe_win_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int IDX_W = (MAX_S > 1) ? $clog2(MAX_S) : 1;
    localparam logic [S_W-1:0] MAX_S_V = S_W'(MAX_S);
    localparam logic [W_W-1:0] MAX_W_V = W_W'(MAX_W);

    feeder_state_t state, state_n;

    logic [S_W-1:0]        s_reg, s_n, idx, idx_n, last_idx;
    logic [W_W-1:0]        nwin_m1, nwin_n, win_cnt, win_cnt_n;
    logic [DATA_WIDTH-1:0] fltr_mem [MAX_S];
    logic [DATA_WIDTH-1:0] win_rd;
    logic [DATA_WIDTH-1:0] pe_ifmap_n, pe_fltr_n;
    logic fltr_we, win_load, win_shift, cfg_bad;
    logic tap_n, acc_n, last_n, done_n, err_n;

    assign last_idx = s_reg - S_W'(1);
    assign cfg_bad  = (cfg_s == '0) || (cfg_s > MAX_S_V) ||
                      (cfg_w < W_W'(cfg_s)) || (cfg_w > MAX_W_V);

    pe_window_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_S      (MAX_S),
        .S_W        (S_W),
        .IDX_W      (IDX_W)
    ) u_win (
        .clk      (clk),
        .load_en  (win_load),
        .load_idx (idx[IDX_W-1:0]),
        .shift_en (win_shift),
        .last_idx (last_idx),
        .din      (ifmap_data),
        .rd_idx   (idx[IDX_W-1:0]),
        .rd_data  (win_rd)
    );

    always_comb begin
        state_n    = state;
        s_n        = s_reg;
        nwin_n     = nwin_m1;
        idx_n      = idx;
        win_cnt_n  = win_cnt;
        pe_ifmap_n = pe_ifmap;
        pe_fltr_n  = pe_fltr;
        fltr_we    = 1'b0;
        win_load   = 1'b0;
        win_shift  = 1'b0;
        tap_n      = 1'b0;
        acc_n      = 1'b0;
        last_n     = 1'b0;
        done_n     = 1'b0;
        err_n      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (cfg_bad) begin
                        err_n = 1'b1;
                    end else begin
                        state_n   = LOAD_F;
                        s_n       = cfg_s;
                        nwin_n    = cfg_w - W_W'(cfg_s);
                        idx_n     = '0;
                        win_cnt_n = '0;
                    end
                end
            end
            LOAD_F: begin
                if (fltr_valid && fltr_ready) begin
                    fltr_we = 1'b1;
                    if (idx == last_idx) begin
                        idx_n   = '0;
                        state_n = FILL;
                    end else begin
                        idx_n = idx + S_W'(1);
                    end
                end
            end
            FILL: begin
                if (ifmap_valid && ifmap_ready) begin
                    win_load = 1'b1;
                    if (idx == last_idx) begin
                        idx_n   = '0;
                        state_n = COMPUTE;
                    end else begin
                        idx_n = idx + S_W'(1);
                    end
                end
            end
            COMPUTE: begin
                // Operands are registered, so the PE sees tap t one cycle after the feeder issues it.
                tap_n      = 1'b1;
                acc_n      = (idx == '0);
                last_n     = (idx == last_idx);
                pe_ifmap_n = win_rd;
                pe_fltr_n  = fltr_mem[idx[IDX_W-1:0]];
                if (idx == last_idx) begin
                    idx_n = '0;
                    if (win_cnt == nwin_m1) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        win_cnt_n = win_cnt + W_W'(1);
                        state_n   = SHIFT;
                    end
                end else begin
                    idx_n = idx + S_W'(1);
                end
            end
            SHIFT: begin
                if (ifmap_valid && ifmap_ready) begin
                    win_shift = 1'b1;
                    state_n   = COMPUTE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            s_reg        <= '0;
            nwin_m1      <= '0;
            idx          <= '0;
            win_cnt      <= '0;
            fltr_ready   <= 1'b0;
            ifmap_ready  <= 1'b0;
            pe_ifmap     <= '0;
            pe_fltr      <= '0;
            pe_mult_seln <= 1'b0;
            pe_acc_seln  <= 1'b0;
            pe_tap_valid <= 1'b0;
            pe_win_last  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= state_n;
            s_reg        <= s_n;
            nwin_m1      <= nwin_n;
            idx          <= idx_n;
            win_cnt      <= win_cnt_n;
            // Ready follows the next state so it never depends on valid.
            fltr_ready   <= (state_n == LOAD_F);
            ifmap_ready  <= (state_n == FILL) || (state_n == SHIFT);
            pe_ifmap     <= pe_ifmap_n;
            pe_fltr      <= pe_fltr_n;
            pe_mult_seln <= tap_n;
            pe_acc_seln  <= acc_n;
            pe_tap_valid <= tap_n;
            pe_win_last  <= last_n;
            busy         <= (state_n != IDLE);
            done         <= done_n;
            err          <= err_n;
        end
    end

    always_ff @(posedge clk) begin
        if (fltr_we) begin
            fltr_mem[idx[IDX_W-1:0]] <= fltr_data;
        end
    end

endmodule

// File: tb/tb_pe_row_feeder.sv
// Self-checking bench for pe_row_feeder: a window/tap model built from the
// job description is compared against the PE-facing outputs every cycle.
module tb_pe_row_feeder;
    import pe_pkg::*;

    localparam int S_W = $clog2(PE_MAX_S + 1);
    localparam int W_W = $clog2(PE_MAX_W + 1);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [S_W-1:0] cfg_s = '0;
    logic [W_W-1:0] cfg_w = '0;
    data_t          fltr_data = '0;
    logic           fltr_valid = 1'b0;
    logic           fltr_ready;
    data_t          ifmap_data = '0;
    logic           ifmap_valid = 1'b0;
    logic           ifmap_ready;
    data_t          pe_ifmap, pe_fltr;
    logic           pe_mult_seln, pe_acc_seln, pe_tap_valid, pe_win_last;
    logic           busy, done, err;

    pe_row_feeder dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_s        (cfg_s),
        .cfg_w        (cfg_w),
        .fltr_data    (fltr_data),
        .fltr_valid   (fltr_valid),
        .fltr_ready   (fltr_ready),
        .ifmap_data   (ifmap_data),
        .ifmap_valid  (ifmap_valid),
        .ifmap_ready  (ifmap_ready),
        .pe_ifmap     (pe_ifmap),
        .pe_fltr      (pe_fltr),
        .pe_mult_seln (pe_mult_seln),
        .pe_acc_seln  (pe_acc_seln),
        .pe_tap_valid (pe_tap_valid),
        .pe_win_last  (pe_win_last),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ifm;
        int flt;
        bit acc;
        bit last;
        bit dn;
    } tap_t;

    int   checks = 0;
    int   errors = 0;
    bit   abort = 1'b0;
    bit   aborted = 1'b0;
    bit   chk_en = 1'b0;
    tap_t exp_q[$];
    int   sums[$];
    int   acc_sum = 0;
    int   done_cnt = 0;
    int   fv[PE_MAX_S];
    int   iv[PE_MAX_W];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Every cycle: taps must match the model in order; idle cycles carry no tap flags.
    always @(negedge clk) begin : compare_proc
        tap_t e;
        if (chk_en && !rst) begin
            if (pe_tap_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("extra_tap", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("pe_ifmap", int'(pe_ifmap), e.ifm);
                    checkOutput("pe_fltr", int'(pe_fltr), e.flt);
                    checkOutput("acc_seln", int'(pe_acc_seln), int'(e.acc));
                    checkOutput("win_last", int'(pe_win_last), int'(e.last));
                    checkOutput("mult_seln", int'(pe_mult_seln), 1);
                    checkOutput("done", int'(done), int'(e.dn));
                    if (pe_acc_seln) acc_sum = 0;
                    acc_sum += int'(pe_ifmap) * int'(pe_fltr);
                    if (pe_win_last) sums.push_back(acc_sum);
                end
            end else begin
                checkOutput("idle_done", int'(done), 0);
                checkOutput("idle_flags", int'({pe_acc_seln, pe_win_last, pe_mult_seln}), 0);
            end
            if (done) done_cnt++;
        end
    end

    task automatic driveFilter(input int s);
        int n;
        for (int i = 0; i < s && !abort; i++) begin
            fltr_data  = data_t'(fv[i]);
            fltr_valid = 1'b1;
            n = 0;
            while (!fltr_ready && !abort && n < 500) begin
                @(negedge clk);
                n++;
            end
            if (n >= 500) begin
                checkOutput("fltr_hs_timeout", 0, 1);
                break;
            end
            if (!abort) @(negedge clk);
        end
        fltr_valid = 1'b0;
    endtask

    task automatic driveIfmap(input int w, input int stall);
        int n;
        for (int i = 0; i < w && !abort; i++) begin
            ifmap_data = data_t'(iv[i]);
            if (i == stall) begin
                ifmap_valid = 1'b0;
                n = 0;
                while (!ifmap_ready && !abort && n < 500) begin
                    @(negedge clk);
                    n++;
                end
                for (int k = 0; k < 4 && !abort; k++) begin
                    @(negedge clk);
                    checkOutput("stall_tap_valid", int'(pe_tap_valid), 0);
                    checkOutput("stall_ready", int'(ifmap_ready), 1);
                end
            end
            ifmap_valid = 1'b1;
            n = 0;
            while (!ifmap_ready && !abort && n < 500) begin
                @(negedge clk);
                n++;
            end
            if (n >= 500) begin
                checkOutput("ifmap_hs_timeout", 0, 1);
                break;
            end
            if (!abort) @(negedge clk);
        end
        ifmap_valid = 1'b0;
    endtask

    task automatic controlJob(input int rst_win, input bit extra_start);
        int n = 0;
        int wins = 0;
        bit kicked = 1'b0;
        while (1) begin
            @(negedge clk);
            n++;
            if (pe_tap_valid && pe_acc_seln) wins++;
            if (rst_win >= 0 && wins == rst_win + 1 && pe_tap_valid && pe_acc_seln) begin
                rst   = 1'b1;
                abort = 1'b1;
                @(negedge clk);
                checkOutput("rst_outputs_zero",
                            int'({fltr_ready, ifmap_ready, pe_ifmap, pe_fltr, pe_mult_seln,
                                  pe_acc_seln, pe_tap_valid, pe_win_last, done, err} != '0), 0);
                checkOutput("rst_busy", int'(busy), 0);
                rst = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (extra_start && !kicked && pe_tap_valid) begin
                kicked = 1'b1;
                cfg_s  = S_W'(1);
                cfg_w  = W_W'(8);
                start  = 1'b1;
                @(negedge clk);
                start = 1'b0;
                n++;
            end
            if (done) break;
            if (n > 2000) begin
                checkOutput("job_timeout", 0, 1);
                abort = 1'b1;
                break;
            end
        end
    endtask

    // Builds the expected tap stream from the job, then runs one job end to end.
    task automatic applyStimulus(input int s, input int w, input int stall,
                                 input int rst_win, input bit extra_start);
        tap_t e;
        exp_q.delete();
        for (int k = 0; k <= w - s; k++) begin
            for (int t = 0; t < s; t++) begin
                e.ifm  = iv[k + t];
                e.flt  = fv[t];
                e.acc  = (t == 0);
                e.last = (t == s - 1);
                e.dn   = (t == s - 1) && (k == w - s);
                exp_q.push_back(e);
            end
        end
        sums.delete();
        done_cnt = 0;
        abort    = 1'b0;
        aborted  = 1'b0;
        chk_en   = 1'b1;
        @(negedge clk);
        cfg_s = S_W'(s);
        cfg_w = W_W'(w);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        fork
            driveFilter(s);
            driveIfmap(w, stall);
            controlJob(rst_win, extra_start);
        join
        if (aborted) begin
            exp_q.delete();
        end else begin
            @(negedge clk);
            checkOutput("busy_after_done", int'(busy), 0);
            checkOutput("taps_left", exp_q.size(), 0);
            checkOutput("done_count", done_cnt, 1);
        end
    endtask

    task automatic loadRow345();
        for (int i = 0; i < 3; i++) fv[i] = i + 1;
        for (int i = 0; i < 5; i++) iv[i] = i + 1;
    endtask

    task automatic checkSums3(input string tag);
        checkOutput({tag, "_windows"}, sums.size(), 3);
        if (sums.size() == 3) begin
            checkOutput({tag, "_sum0"}, sums[0], 14);
            checkOutput({tag, "_sum1"}, sums[1], 20);
            checkOutput({tag, "_sum2"}, sums[2], 26);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs_zero",
                    int'({fltr_ready, ifmap_ready, pe_ifmap, pe_fltr, pe_mult_seln, pe_acc_seln,
                          pe_tap_valid, pe_win_last, busy, done, err} != '0), 0);
        rst = 1'b0;

        loadRow345();
        applyStimulus(3, 5, -1, -1, 1'b0);
        checkSums3("basic");

        applyStimulus(3, 5, 3, -1, 1'b0);
        checkSums3("stall");

        begin
            int bad_s[4] = '{0, 9, 4, 2};
            int bad_w[4] = '{5, 20, 3, 300};
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                cfg_s = S_W'(bad_s[c]);
                cfg_w = W_W'(bad_w[c]);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                checkOutput("err_pulse", int'(err), 1);
                checkOutput("err_busy", int'(busy), 0);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    checkOutput("err_ready", int'({fltr_ready, ifmap_ready}), 0);
                    checkOutput("err_one_cycle", int'(err), 0);
                    checkOutput("err_busy_hold", int'(busy), 0);
                end
            end
        end

        fv[0] = 5;
        for (int i = 0; i < 4; i++) iv[i] = i + 1;
        applyStimulus(1, 4, -1, -1, 1'b0);
        checkOutput("s1_windows", sums.size(), 4);
        if (sums.size() == 4) begin
            checkOutput("s1_sum0", sums[0], 5);
            checkOutput("s1_sum3", sums[3], 20);
        end

        loadRow345();
        applyStimulus(3, 5, -1, 1, 1'b0);
        checkOutput("rst_aborted", int'(aborted), 1);
        checkOutput("rst_no_done", done_cnt, 0);
        fv[0] = 7;
        fv[1] = 3;
        iv[0] = 4;
        iv[1] = 6;
        applyStimulus(2, 2, -1, -1, 1'b0);
        checkOutput("post_rst_windows", sums.size(), 1);
        if (sums.size() == 1) checkOutput("post_rst_sum", sums[0], 46);

        loadRow345();
        applyStimulus(3, 5, -1, -1, 1'b1);
        checkSums3("restart_ignored");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
